// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line side (master) drives the serial input and
// the parity mode, and the receiver (slave) returns the decoded frame.
interface uart_rx_if;
  logic       rx_in;
  logic       parity_enable;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  modport master (
    output rx_in,
    output parity_enable,
    input  data_out,
    input  data_valid,
    input  parity_error,
    input  framing_error,
    input  busy
  );

  modport slave (
    input  rx_in,
    input  parity_enable,
    output data_out,
    output data_valid,
    output parity_error,
    output framing_error,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits sent LSB first, optional even parity, one stop bit.
// Bits are sampled at mid-bit, timed from the falling edge of the start bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic     clk,
  input logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             parity_error_q, parity_error_d;
  logic             framing_error_q, framing_error_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_prev_q, rx_prev_d;

  // Two-flop synchronizer, plus a delayed copy of the synchronized line for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit timing, data shifting and the output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_en_q        <= 1'b0;
      par_bit_q       <= 1'b0;
      data_out_q      <= 8'h00;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_en_q        <= par_en_d;
      par_bit_q       <= par_bit_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  // Next-state and datapath logic: each state counts to its sample point, samples, then restarts the counter
  always_comb begin
    sync1_d         = bus.rx_in;
    rx_s_d          = sync1_q;
    rx_prev_d       = rx_s_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_en_d        = par_en_q;
    par_bit_d       = par_bit_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_en_d  = bus.parity_enable;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d           = '0;
          state_d         = IDLE;
          data_valid_d    = 1'b1;
          data_out_d      = shift_q;
          framing_error_d = !rx_s_q;
          parity_error_d  = par_en_q & ((^shift_q) ^ par_bit_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_out      = data_out_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: each frame's expected result goes into a queue
// when it is sent, and a monitor checks it against every data_valid pulse.
module tb_uart_rx;

  localparam int N         = 16;
  localparam int H         = N / 2;
  localparam int LAT_NOPAR = 2 + H + 9 * N + 1;
  localparam int LAT_PAR   = 2 + H + 10 * N + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t sb[$];

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and a cycle counter used to check latency
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic driveBit(input logic v);
    bus.rx_in = v;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idleBits(input int n);
    for (int i = 0; i < n; i++) driveBit(1'b1);
  endtask

  // Sends one complete frame and queues its hand-computed result; parity_enable is
  // flipped after the start bit so a frame only honours the value it latched.
  task automatic applyStimulus(input logic [7:0] d, input logic par_on, input logic par_bit,
                               input logic stop_bit, input logic [7:0] exp_data,
                               input logic exp_perr, input logic exp_ferr, input int exp_lat);
    exp_t e;
    bus.parity_enable = par_on;
    e.data = exp_data;
    e.perr = exp_perr;
    e.ferr = exp_ferr;
    e.due  = cyc + exp_lat;
    sb.push_back(e);
    driveBit(1'b0);
    bus.parity_enable = ~par_on;
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    if (par_on) driveBit(par_bit);
    driveBit(stop_bit);
  endtask

  // Monitor: every data_valid pulse is checked against the oldest queued frame
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.data_valid === 1'b1) begin
        checkOutput("valid_single_cycle", {31'd0, prev_v}, 32'd0);
        if (sb.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_valid: got data_valid=1 data_out=%0h, expected no frame (cycle %0d)",
                   bus.data_out, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
          checkOutput("parity_error", {31'd0, bus.parity_error}, {31'd0, e.perr});
          checkOutput("framing_error", {31'd0, bus.framing_error}, {31'd0, e.ferr});
          checkOutput("latency_cycle", cyc, e.due);
        end
      end
      prev_v = bus.data_valid;
    end
  end

  // Safety net so the run always ends
  initial begin
    #(500000);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    bus.rx_in         = 1'b1;
    bus.parity_enable = 1'b0;
    rst_n             = 1'b0;
    #2;
    checkOutput("reset_data_out", {24'd0, bus.data_out}, 32'h00);
    checkOutput("reset_data_valid", {31'd0, bus.data_valid}, 32'd0);
    checkOutput("reset_parity_error", {31'd0, bus.parity_error}, 32'd0);
    checkOutput("reset_framing_error", {31'd0, bus.framing_error}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleBits(2);

    $display("[TB] basic frame 8'hA5, parity off");
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, LAT_NOPAR);
    idleBits(1);

    $display("[TB] parity frames 8'hAB with good and bad parity bit");
    applyStimulus(8'hAB, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, LAT_PAR);
    applyStimulus(8'hAB, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b1, 1'b0, LAT_PAR);
    idleBits(1);

    $display("[TB] framing error 8'h3C, then line held low");
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, LAT_NOPAR);
    for (int i = 0; i < 40; i++) driveBit(1'b0);
    checkOutput("busy_line_held_low", {31'd0, bus.busy}, 32'd0);
    idleBits(2);
    checkOutput("busy_after_line_high", {31'd0, bus.busy}, 32'd0);

    $display("[TB] false start pulse of 4 cycles");
    bus.rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("busy_during_false_start", {31'd0, bus.busy}, 32'd1);
    bus.rx_in = 1'b1;
    idleBits(2);
    checkOutput("busy_after_false_start", {31'd0, bus.busy}, 32'd0);
    checkOutput("data_out_after_false_start", {24'd0, bus.data_out}, 32'h3C);
    checkOutput("framing_error_held", {31'd0, bus.framing_error}, 32'd1);

    $display("[TB] back-to-back frames 8'h01 and 8'hFE");
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, LAT_NOPAR);
    applyStimulus(8'hFE, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, LAT_NOPAR);
    idleBits(1);

    $display("[TB] reset during data bit 4 of 8'h55");
    bus.parity_enable = 1'b0;
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    bus.rx_in = 1'b1;
    repeat (H) @(posedge clk);
    #1;
    checkOutput("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_data_out", {24'd0, bus.data_out}, 32'h00);
    checkOutput("midreset_data_valid", {31'd0, bus.data_valid}, 32'd0);
    checkOutput("midreset_parity_error", {31'd0, bus.parity_error}, 32'd0);
    checkOutput("midreset_framing_error", {31'd0, bus.framing_error}, 32'd0);
    checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
    repeat (N) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleBits(2);
    checkOutput("busy_after_reset_release", {31'd0, bus.busy}, 32'd0);

    $display("[TB] frame 8'h0F after reset");
    applyStimulus(8'h0F, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, LAT_NOPAR);
    idleBits(2);

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal values are even integers >= 4.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port parity_enable  input  1  when 1, an even-parity bit follows the data bits.
REQ-006 SHALL have port data_out  output  8  last received byte.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse marking a completed frame.
REQ-008 SHALL have port parity_error  output  1  parity check result for the frame flagged by data_valid.
REQ-009 SHALL have port framing_error  output  1  stop-bit check result for the frame flagged by data_valid.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rx_in through a 2-flop synchronizer; both flops reset to 1; all further logic uses the synchronized value (rx_s).
REQ-012 SHALL accept frame format: start bit 0, 8 data bits LSB first, optional parity bit, one stop bit 1.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START on a falling edge of rx_s (previous sample 1, current sample 0); a line held low never retriggers.
REQ-015 START: after CLKS_PER_BIT/2 cycles, sample rx_s; 1 -> false start, return to IDLE with no output change; 0 -> DATA with bit counter cleared.
REQ-016 SHALL latch parity_enable on the START->DATA transition; changes mid-frame have no effect on the current frame.
REQ-017 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit); shift each sample into bit position 0..7 in order; after the 8th sample go to PARITY if latched enable = 1, else STOP.
REQ-018 PARITY: sample after CLKS_PER_BIT cycles; error = XOR of the 8 data bits and the parity bit (even parity, so a correct frame gives 0).
REQ-019 STOP: sample after CLKS_PER_BIT cycles; framing error = (sample == 0).
REQ-020 On the cycle after the stop sample: data_valid = 1 for exactly one cycle; data_out, parity_error and framing_error update in that same cycle; FSM returns to IDLE.
REQ-021 SHALL report frames with errors as well: data_valid pulses and data_out updates regardless of either error flag.
REQ-022 parity_error SHALL be 0 for frames received with parity disabled.
REQ-023 data_out, parity_error and framing_error SHALL hold their values until the next data_valid.
REQ-024 SHALL use a bit-period counter of width ceil(log2(CLKS_PER_BIT)) that restarts at every sample point; no wrap beyond CLKS_PER_BIT-1.
REQ-025 Frame latency SHALL be start-edge-to-data_valid = 2 (sync) + CLKS_PER_BIT/2 + (9 or 10)*CLKS_PER_BIT + 1 cycles, with 9 for parity disabled and 10 for parity enabled.
REQ-026 SHALL be able to detect a new start edge in the first IDLE cycle after data_valid (back-to-back frames).

Reset
REQ-027 On rst_n low, immediately and regardless of clk: FSM = IDLE, counters = 0, data_out = 8'h00, data_valid = 0, parity_error = 0, framing_error = 0, busy = 0, synchronizer = 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no data_valid; the first frame after reset release requires a fresh falling edge.

Verification
REQ-029 CLKS_PER_BIT = 16, parity off, send 8'hA5 with stop = 1 -> data_out = 8'hA5, data_valid one cycle, both errors 0, latency per REQ-025.
REQ-030 Parity on, send 8'hAB with parity bit 1 -> parity_error = 0; repeat with parity bit 0 -> parity_error = 1, data_out = 8'hAB.
REQ-031 Send 8'h3C with stop bit 0, then hold the line low for 40 bits -> framing_error = 1, exactly one data_valid, no retrigger until the line returns high.
REQ-032 Pulse rx_in low for 4 cycles while IDLE -> false start, no data_valid, data_out unchanged, busy returns 0.
REQ-033 Back-to-back frames 8'h01 then 8'hFE with no idle gap -> two data_valid pulses with correct bytes.
REQ-034 Assert rst_n low during data bit 4 of 8'h55 -> outputs at reset values, no data_valid; the next full frame 8'h0F is received correctly.
